// File: rtl/aes_subbytes_seq.sv
// Sequential SubBytes / InvSubBytes engine for one 128-bit AES state.
// LANES forward and LANES inverse S-boxes are applied to the working register
// W, LANES bytes per cycle, over NSTEP = 16/LANES cycles. Both handshakes use
// valid/ready. The result is held in W and presented until downstream takes it.
module aes_subbytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NSTEP = 16 / LANES;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  // Only lane counts that divide the 16 state bytes into whole steps are usable.
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic, modulus x^8 + x^4 + x^3 + x + 1
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) begin
        acc = acc ^ aa;
      end
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  // The loop builds a^(2^n - 1) up to a^127, one final squaring gives a^254.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    p = a;
    for (int k = 0; k < 6; k++) begin
      p = gf_mul(gf_mul(p, p), a);
    end
    return gf_mul(p, p);
  endfunction

  // Forward S-box: inversion followed by the affine map (constant 0x63).
  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Inverse S-box: inverse affine map (constant 0x05) followed by inversion.
  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [127:0]    w_q, w_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dir_q, dir_d;

  logic [3:0]      lane_idx [LANES];
  logic [7:0]      lane_byte [LANES];
  logic [7:0]      lane_res [LANES];

  // ---------------------------------------------------------------------------
  // S-box lanes: lane gi works on byte cnt*LANES + gi of W
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] fwd_out;
    logic [7:0] inv_out;

    assign lane_idx[gi]  = 4'((32'(cnt_q) * LANES) + gi);
    assign lane_byte[gi] = w_q[{lane_idx[gi], 3'b000} +: 8];
    assign fwd_out       = sbox_fwd(lane_byte[gi]);
    assign inv_out       = sbox_inv(lane_byte[gi]);
    assign lane_res[gi]  = dir_q ? inv_out : fwd_out;
  end

  // ---------------------------------------------------------------------------
  // Handshake outputs; in_ready is masked while reset is asserted
  // ---------------------------------------------------------------------------
  assign in_ready  = (state_q == ST_IDLE) && reset;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign out_state = w_q;

  // Next-state logic: accept in IDLE, substitute in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          w_d     = in_state;
          dir_d   = in_inv;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        for (int l = 0; l < LANES; l++) begin
          w_d[{lane_idx[l], 3'b000} +: 8] = lane_res[l];
        end
        if (cnt_q == CW'(NSTEP - 1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; asynchronous reset discards any block in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Testbench for aes_subbytes_seq: known-answer vectors, randomized blocks
// against a brute-force S-box model, backpressure, input sampling, async
// reset and lane-count regression.
module tb_aes_subbytes_seq;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         in_inv;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  // Lane-count regression instances share stimulus, have their own valid.
  logic         rv_in_valid;
  logic [3:0]   rv_ready;
  logic [3:0]   rv_valid;
  logic [3:0]   rv_busy;
  logic [127:0] rv_state [4];

  int checks;
  int errors;

  logic [7:0] sbox_m  [256];
  logic [7:0] isbox_m [256];

  localparam logic [127:0] VEC1 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] EXP1 = 128'h76abd7fe2b670130c56f6bf27b777c63;

  aes_subbytes_seq #(.LANES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_inv(in_inv), .in_state(in_state), .out_valid(out_valid),
    .out_ready(out_ready), .out_state(out_state), .busy(busy)
  );

  aes_subbytes_seq #(.LANES(1)) u_l1 (
    .clk(clk), .reset(reset), .in_valid(rv_in_valid), .in_ready(rv_ready[0]),
    .in_inv(in_inv), .in_state(in_state), .out_valid(rv_valid[0]),
    .out_ready(1'b1), .out_state(rv_state[0]), .busy(rv_busy[0])
  );
  aes_subbytes_seq #(.LANES(2)) u_l2 (
    .clk(clk), .reset(reset), .in_valid(rv_in_valid), .in_ready(rv_ready[1]),
    .in_inv(in_inv), .in_state(in_state), .out_valid(rv_valid[1]),
    .out_ready(1'b1), .out_state(rv_state[1]), .busy(rv_busy[1])
  );
  aes_subbytes_seq #(.LANES(8)) u_l8 (
    .clk(clk), .reset(reset), .in_valid(rv_in_valid), .in_ready(rv_ready[2]),
    .in_inv(in_inv), .in_state(in_state), .out_valid(rv_valid[2]),
    .out_ready(1'b1), .out_state(rv_state[2]), .busy(rv_busy[2])
  );
  aes_subbytes_seq #(.LANES(16)) u_l16 (
    .clk(clk), .reset(reset), .in_valid(rv_in_valid), .in_ready(rv_ready[3]),
    .in_inv(in_inv), .in_state(in_state), .out_valid(rv_valid[3]),
    .out_ready(1'b1), .out_state(rv_state[3]), .busy(rv_busy[3])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Reference model: inverse found by exhaustive search, affine map bitwise
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int prod;
    prod = 0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (int'(a) << i);
    for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (32'h11b << (i - 8));
    return prod[7:0];
  endfunction

  task automatic build_model();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
      sbox_m[x]  = s;
      isbox_m[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model_block(input logic [127:0] st, input logic inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv ? isbox_m[st[8*i +: 8]] : sbox_m[st[8*i +: 8]];
    return r;
  endfunction

  // Stimulus: called at posedge+1 with the DUT idle. Returns the result and
  // the number of edges from accept to out_valid (-1 on timeout), then drains.
  task automatic run_block(input logic [127:0] st, input logic inv, input logic rdy,
                           output logic [127:0] res, output int lat);
    in_state  = st;
    in_inv    = inv;
    in_valid  = 1'b1;
    out_ready = rdy;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_inv   = 1'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_state;
    if (out_valid !== 1'b1) lat = -1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (out_state !== 128'h0) begin errors++; $display("FAIL reset_out_state: got %h expected 0", out_state); end
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_fwd_vector();
    logic [127:0] res;
    int lat;
    run_block(VEC1, 1'b0, 1'b0, res, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL fwd_latency: got %0d expected 4", lat); end
    checks++; if (res !== EXP1) begin errors++; $display("FAIL fwd_vector: got %h expected %h", res, EXP1); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fwd_idle_after: got %b expected 1", in_ready); end
    $display("fwd vector: out=%h lat=%0d", res, lat);
  endtask

  task automatic test_inv_vector();
    logic [127:0] res;
    logic [127:0] st;
    int lat;
    run_block(EXP1, 1'b1, 1'b0, res, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL inv_latency: got %0d expected 4", lat); end
    checks++; if (res !== VEC1) begin errors++; $display("FAIL inv_vector: got %h expected %h", res, VEC1); end
    $display("inv vector: out=%h lat=%0d", res, lat);
    st = {$urandom, $urandom, $urandom, 16'($urandom), 8'hff, 8'h53};
    run_block(st, 1'b0, 1'b0, res, lat);
    checks++; if (res[7:0] !== 8'hed) begin errors++; $display("FAIL spot_S53: got %h expected ed", res[7:0]); end
    checks++; if (res[15:8] !== 8'h16) begin errors++; $display("FAIL spot_Sff: got %h expected 16", res[15:8]); end
    st = {$urandom, $urandom, $urandom, 24'($urandom), 8'h63};
    run_block(st, 1'b1, 1'b0, res, lat);
    checks++; if (res[7:0] !== 8'h00) begin errors++; $display("FAIL spot_Sinv63: got %h expected 00", res[7:0]); end
    checks++; if (res !== model_block(st, 1'b1)) begin errors++; $display("FAIL spot_inv_block: got %h expected %h", res, model_block(st, 1'b1)); end
    $display("spot checks: last out=%h", res);
  endtask

  task automatic test_backpressure();
    logic [127:0] st;
    logic [127:0] snap;
    int cyc;
    st = {$urandom, $urandom, $urandom, $urandom};
    in_state = st; in_inv = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout: got out_valid %b expected 1", out_valid); end
    snap = out_state;
    checks++; if (snap !== model_block(st, 1'b0)) begin errors++; $display("FAIL bp_value: got %h expected %h", snap, model_block(st, 1'b0)); end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_state !== snap || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got v=%b r=%b busy=%b st=%h expected v=1 r=0 busy=1 st=%h",
                 i, out_valid, in_ready, busy, out_state, snap);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_no_turnaround: got in_ready %b expected 0", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got v=%b r=%b busy=%b expected v=0 r=1 busy=0", out_valid, in_ready, busy);
    end
    $display("backpressure: held %h for 10 cycles", snap);
  endtask

  task automatic test_toggle();
    logic [127:0] st;
    logic inv;
    int cyc;
    st  = {$urandom, $urandom, $urandom, $urandom};
    inv = 1'($urandom);
    in_state = st; in_inv = inv; in_valid = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      in_state = {$urandom, $urandom, $urandom, $urandom};
      in_inv   = ~in_inv;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (cyc != 4) begin errors++; $display("FAIL toggle_latency: got %0d expected 4", cyc); end
    checks++; if (out_state !== model_block(st, inv)) begin errors++; $display("FAIL toggle_value: got %h expected %h", out_state, model_block(st, inv)); end
    $display("toggle: in=%h inv=%b out=%h", st, inv, out_state);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [127:0] st;
    logic [127:0] res;
    logic inv;
    logic rdy;
    int lat;
    for (int n = 0; n < 24; n++) begin
      st  = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom);
      rdy = 1'($urandom);
      run_block(st, inv, rdy, res, lat);
      checks++;
      if (lat != 4 || res !== model_block(st, inv)) begin
        errors++;
        $display("FAIL random_%0d: got %h lat %0d expected %h lat 4", n, res, lat, model_block(st, inv));
      end
      $display("random %0d: in=%h inv=%b rdy=%b out=%h", n, st, inv, rdy, res);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset_midrun();
    logic [127:0] res;
    int lat;
    in_state = {$urandom, $urandom, $urandom, $urandom}; in_inv = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_state !== 128'h0) begin
      errors++;
      $display("FAIL midrun_reset: got v=%b busy=%b r=%b st=%h expected 0 0 0 0", out_valid, busy, in_ready, out_state);
    end
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midrun_release: got r=%b busy=%b expected r=1 busy=0", in_ready, busy); end
    @(posedge clk); #1;
    run_block(VEC1, 1'b0, 1'b0, res, lat);
    checks++; if (res !== EXP1 || lat != 4) begin errors++; $display("FAIL midrun_next: got %h lat %0d expected %h lat 4", res, lat, EXP1); end
    $display("reset midrun: next block out=%h", res);
  endtask

  task automatic test_lanes();
    int exp_lat [4];
    int got_lat [4];
    logic [127:0] got_st [4];
    exp_lat = '{16, 8, 2, 1};
    got_lat = '{-1, -1, -1, -1};
    checks++; if (rv_ready !== 4'hf) begin errors++; $display("FAIL lanes_ready: got %b expected 1111", rv_ready); end
    in_state = VEC1; in_inv = 1'b0; rv_in_valid = 1'b1;
    @(posedge clk); #1;
    rv_in_valid = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_inv   = 1'b1;
    checks++; if (rv_busy !== 4'hf) begin errors++; $display("FAIL lanes_busy: got %b expected 1111", rv_busy); end
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (rv_valid[i] === 1'b1 && got_lat[i] < 0) begin
          got_lat[i] = cyc;
          got_st[i]  = rv_state[i];
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_lat[i] != exp_lat[i] || got_st[i] !== EXP1) begin
        errors++;
        $display("FAIL lanes_%0d: got %h lat %0d expected %h lat %0d", 16 / exp_lat[i], got_st[i], got_lat[i], EXP1, exp_lat[i]);
      end
      $display("lanes %0d: lat=%0d out=%h", 16 / exp_lat[i], got_lat[i], got_st[i]);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    in_valid = 1'b0;
    rv_in_valid = 1'b0;
    in_inv = 1'b0;
    in_state = '0;
    out_ready = 1'b0;
    build_model();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_fwd_vector();
    test_inv_vector();
    test_backpressure();
    test_toggle();
    test_random();
    test_reset_midrun();
    test_lanes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
